// File: rtl/stepper_seek_ctrl_pkg.sv
// stepper_seek_ctrl_pkg: command/state encodings and the {hi,lo} coil phase table.
package stepper_seek_ctrl_pkg;
  typedef enum logic [1:0] {OP_STOP, OP_HOME, OP_SEEK, OP_JOG} cmd_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_DEAD, ST_DWELL, ST_CHECK} state_e;
  // {hi[3:0], lo[3:0]} per phase index, terminal order {B-,B+,A-,A+}
  localparam logic [7:0] PHASE_TBL [8] = '{8'h12, 8'h5A, 8'h48, 8'h69, 8'h21, 8'hA5, 8'h84, 8'h96};
endpackage

// File: rtl/stepper_seek_ctrl_if.sv
// stepper_seek_ctrl_if: command valid/ready handshake from the bus-register decode.
interface stepper_seek_ctrl_if #(parameter int CNT_W = 16);
  import stepper_seek_ctrl_pkg::*;
  logic             cmd_valid;
  logic             cmd_ready;
  cmd_op_e          cmd_op;
  logic [CNT_W-1:0] cmd_arg;
  modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_arg, output cmd_ready);
endinterface

// File: rtl/stepper_seek_ctrl_sensor_debounce.sv
// sensor_debounce: 2-FF synchroniser followed by a stability counter on the synced bus.
module sensor_debounce #(
  parameter int W      = 1,
  parameter int DB_CYC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] db_o
);
  localparam int CW = $clog2(DB_CYC + 1);
  logic [W-1:0]  s1_q, s2_q, cand_q, db_q;
  logic [CW-1:0] cnt_q;
  assign db_o = db_q;
  // cand_q tracks the whole bus so a multi-bit code must be stable as one word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      db_q   <= '0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= CW'(1);
      end else if (cnt_q != CW'(DB_CYC)) cnt_q <= cnt_q + 1'b1;
      if (cnt_q == CW'(DB_CYC)) db_q <= cand_q;
    end
  end
endmodule

// File: rtl/stepper_seek_ctrl.sv
// stepper_seek_ctrl: bipolar stepper sequencer with dead-time insertion and home/position seek.
module stepper_seek_ctrl
  import stepper_seek_ctrl_pkg::*;
#(
  parameter int POS_W    = 3,
  parameter int CNT_W    = 16,
  parameter int DIV_W    = 16,
  parameter int DEAD_CYC = 4,
  parameter int DB_CYC   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  stepper_seek_ctrl_if.slave cmd,
  input  logic               cfg_half_i,
  input  logic               cfg_hold_i,
  input  logic [DIV_W-1:0]   cfg_div_i,
  input  logic [CNT_W-1:0]   cfg_max_i,
  input  logic [POS_W-1:0]   pos_sense_i,
  input  logic               home_sense_i,
  output logic               led_en_o,
  output logic [3:0]         drv_hi_o,
  output logic [3:0]         drv_lo_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_timeout_o,
  output logic [CNT_W-1:0]   step_count_o,
  output logic [POS_W-1:0]   pos_db_o
);
  localparam int DW = $clog2(DEAD_CYC + 1);
  state_e           state_q;
  cmd_op_e          op_q;
  logic [CNT_W-1:0] tgt_q, cnt_q, cnt_inc, mag;
  logic [DIV_W-1:0] div_q, div_ld;
  logic [DW-1:0]    dcnt_q, off_q;
  logic [2:0]       idx_q, nxt_idx;
  logic [7:0]       drv_q;
  logic             dir_q, done_q, err_q, home_db, acc, term_now, term_chk, tmo;
  sensor_debounce #(.W(POS_W), .DB_CYC(DB_CYC)) u_pos_db (
    .clk(clk), .rst_n(rst_n), .raw_i(pos_sense_i), .db_o(pos_db_o));
  sensor_debounce #(.W(1), .DB_CYC(DB_CYC)) u_home_db (
    .clk(clk), .rst_n(rst_n), .raw_i(home_sense_i), .db_o(home_db));
  assign cmd.cmd_ready = (state_q == ST_IDLE) | (cmd.cmd_op == OP_STOP);
  assign acc           = cmd.cmd_valid & cmd.cmd_ready;
  assign mag           = cmd.cmd_arg[CNT_W-1] ? -cmd.cmd_arg : cmd.cmd_arg;
  assign term_now      = (cmd.cmd_op == OP_HOME) ? home_db :
                         (cmd.cmd_op == OP_SEEK) ? (pos_db_o == cmd.cmd_arg[POS_W-1:0]) & ~home_db :
                         (cmd.cmd_arg == '0);
  assign cnt_inc       = &cnt_q ? cnt_q : cnt_q + 1'b1;
  assign term_chk      = (op_q == OP_HOME) ? home_db :
                         (op_q == OP_SEEK) ? (pos_db_o == tgt_q[POS_W-1:0]) & ~home_db :
                         (cnt_inc == tgt_q);
  assign tmo           = (op_q != OP_JOG) & (cnt_inc == cfg_max_i);
  // full-step forces the odd (two-coil) indices, which also snaps an even index on the way
  assign nxt_idx       = cfg_half_i ? idx_q + (dir_q ? 3'd7 : 3'd1) : (idx_q | 3'd1) + (dir_q ? 3'd6 : 3'd2);
  assign div_ld        = (cfg_div_i == '0) ? DIV_W'(1) : cfg_div_i;
  assign {drv_hi_o, drv_lo_o} = drv_q;
  assign busy_o        = state_q != ST_IDLE;
  assign led_en_o      = busy_o & (op_q != OP_JOG);
  assign done_o        = done_q;
  assign err_timeout_o = err_q;
  assign step_count_o  = cnt_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_STOP;
      tgt_q   <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      dcnt_q  <= '0;
      off_q   <= '0;
      idx_q   <= '0;
      drv_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (acc && cmd.cmd_op == OP_STOP) begin
        state_q <= ST_IDLE;
        drv_q   <= '0;
        off_q   <= DW'(DEAD_CYC - 1);
        done_q  <= 1'b1;
      end else if (acc) begin
        op_q  <= cmd.cmd_op;
        tgt_q <= (cmd.cmd_op == OP_JOG) ? mag : cmd.cmd_arg;
        dir_q <= (cmd.cmd_op == OP_JOG) & cmd.cmd_arg[CNT_W-1];
        cnt_q <= '0;
        err_q <= 1'b0;
        if (term_now) done_q <= 1'b1;
        else begin
          state_q <= ST_DEAD;
          drv_q   <= '0;
          dcnt_q  <= DW'(DEAD_CYC - 1);
          off_q   <= '0;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            drv_q <= (off_q != '0 || !cfg_hold_i) ? 8'h00 : PHASE_TBL[idx_q];
            if (off_q != '0) off_q <= off_q - 1'b1;
          end
          ST_DEAD: begin
            if (dcnt_q == '0) begin
              state_q <= ST_DWELL;
              idx_q   <= nxt_idx;
              drv_q   <= PHASE_TBL[nxt_idx];
              div_q   <= div_ld;
            end else dcnt_q <= dcnt_q - 1'b1;
          end
          ST_DWELL: begin
            if (div_q == DIV_W'(1)) state_q <= ST_CHECK;
            else div_q <= div_q - 1'b1;
          end
          default: begin
            cnt_q <= cnt_inc;
            if (term_chk || tmo) begin
              state_q <= ST_IDLE;
              done_q  <= 1'b1;
              err_q   <= ~term_chk;
            end else begin
              state_q <= ST_DEAD;
              drv_q   <= '0;
              dcnt_q  <= DW'(DEAD_CYC - 1);
            end
          end
        endcase
      end
    end
  end
endmodule
